// File: rtl/car_park_pkg.sv
// Shared types and helpers for the multilane car-park occupancy block.
package car_park_pkg;

    typedef enum logic [2:0] {
        IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR
    } lane_state_t;

    // Sensor patterns written {a,b}.
    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_A    = 2'b10;
    localparam logic [1:0] P_AB   = 2'b11;
    localparam logic [1:0] P_B    = 2'b01;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/car_park_multilane_lane_dir_fsm.sv
// Per-lane direction decoder: turns a complete a/b beam sequence into one enter or exit pulse.
module lane_dir_fsm
    import car_park_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter_pulse,
    output logic exit_pulse
);

    lane_state_t state;
    logic [1:0]  p;

    assign p = {a, b};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            if (p == P_NONE) begin
                // Beams clear: a pass completes only from the last step, otherwise it is aborted.
                state       <= IDLE;
                enter_pulse <= (state == EN3);
                exit_pulse  <= (state == EX3);
            end else begin
                case (state)
                    IDLE: state <= (p == P_A) ? EN1 : (p == P_B) ? EX1 : ERR;
                    EN1:  state <= (p == P_A) ? EN1 : (p == P_AB) ? EN2 : ERR;
                    EN2:  state <= (p == P_A) ? EN1 : (p == P_B) ? EN3 : EN2;
                    EN3:  state <= (p == P_B) ? EN3 : (p == P_AB) ? EN2 : ERR;
                    EX1:  state <= (p == P_B) ? EX1 : (p == P_AB) ? EX2 : ERR;
                    EX2:  state <= (p == P_B) ? EX1 : (p == P_A) ? EX3 : EX2;
                    EX3:  state <= (p == P_A) ? EX3 : (p == P_AB) ? EX2 : ERR;
                    default: state <= ERR;
                endcase
            end
        end
    end

endmodule

// File: rtl/car_park_multilane.sv
// Multilane car-park occupancy: per-lane direction FSMs feeding one saturating occupancy counter.
module car_park_multilane
    import car_park_pkg::*;
#(
    parameter  int LANES    = 2,
    parameter  int CAPACITY = 15,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic [CNT_W-1:0] total,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] enter_pulse,
    output logic [LANES-1:0] exit_pulse,
    output logic             overflow,
    output logic             underflow
);

    localparam logic        [CNT_W-1:0] CAP_U = CNT_W'(CAPACITY);
    localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W + 4)'(CAPACITY);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_dir_fsm u_lane (
            .clk         (clk),
            .reset       (reset),
            .a           (a[i]),
            .b           (b[i]),
            .enter_pulse (enter_pulse[i]),
            .exit_pulse  (exit_pulse[i])
        );
    end

    logic [3:0]              n_in;
    logic [3:0]              n_out;
    logic signed [CNT_W+3:0] req;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        n_in  = popcount8(8'(enter_pulse));
        n_out = popcount8(8'(exit_pulse));
        req   = $signed({4'b0000, total})
              + $signed({{CNT_W{1'b0}}, n_in})
              - $signed({{CNT_W{1'b0}}, n_out});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            total     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (req > CAP_S) begin
                total    <= CAP_U;
                overflow <= 1'b1;
            end else if (req[CNT_W+3]) begin
                total     <= '0;
                underflow <= 1'b1;
            end else begin
                total <= req[CNT_W-1:0];
            end
        end
    end

    assign full  = (total == CAP_U);
    assign empty = (total == '0);

endmodule

// File: tb/tb_car_park_multilane.sv
// Scoreboard bench for car_park_multilane: stimulus queues expected events, a monitor pops them.
module tb_car_park_multilane;

    logic       clk;
    logic       reset;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] total;
    logic       full;
    logic       empty;
    logic [1:0] enter_pulse;
    logic [1:0] exit_pulse;
    logic       overflow;
    logic       underflow;

    typedef struct packed {
        logic [1:0] en;
        logic [1:0] ex;
        logic       ovf;
        logic       unf;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    car_park_multilane #(.LANES(2), .CAPACITY(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .total       (total),
        .full        (full),
        .empty       (empty),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step(input logic [1:0] p1, input logic [1:0] p0);
        a = {p1[1], p0[1]};
        b = {p1[0], p0[0]};
        @(posedge clk);
        #1;
    endtask

    task automatic lane_step(input int lane, input logic [1:0] p);
        if (lane == 0) step(2'b00, p);
        else           step(p, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00);
    endtask

    function automatic ev_t mk(input logic [1:0] en, input logic [1:0] ex,
                               input logic ovf, input logic unf);
        ev_t e;
        e = {en, ex, ovf, unf};
        return e;
    endfunction

    task automatic do_entry(input int lane);
        lane_step(lane, 2'b10);
        lane_step(lane, 2'b11);
        lane_step(lane, 2'b01);
        exp_q.push_back(mk((lane == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, 1'b0));
        lane_step(lane, 2'b00);
    endtask

    task automatic do_exit(input int lane);
        lane_step(lane, 2'b01);
        lane_step(lane, 2'b11);
        lane_step(lane, 2'b10);
        exp_q.push_back(mk(2'b00, (lane == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0));
        lane_step(lane, 2'b00);
    endtask

    // Monitor: any non-zero event output must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t got;
        got = {enter_pulse, exit_pulse, overflow, underflow};
        if (reset === 1'b1 && got != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event got %b expected none", got);
            end else begin
                check("event", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_total", 32'(total), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_full",  32'(full),  0);
        check("reset_pulses", 32'({enter_pulse, exit_pulse, overflow, underflow}), 0);
        reset = 1'b1;
        idle(1);

        // Single entry on lane 0: total appears one cycle after the pulse.
        do_entry(0);
        check("entry_total_pulse_cycle", 32'(total), 0);
        idle(1);
        check("entry_total", 32'(total), 1);
        check("entry_empty", 32'(empty), 0);

        do_entry(0); idle(1);
        do_entry(0); idle(1);
        check("total_three", 32'(total), 3);

        // Exit on lane 1, then an aborted entry on lane 1.
        do_exit(1); idle(1);
        check("exit_total", 32'(total), 2);
        lane_step(1, 2'b10);
        lane_step(1, 2'b11);
        lane_step(1, 2'b10);
        lane_step(1, 2'b00);
        idle(2);
        check("abort_total", 32'(total), 2);

        // Skipped step drives lane 0 to ERR; recovery only via 00.
        lane_step(0, 2'b10);
        lane_step(0, 2'b01);
        lane_step(0, 2'b10);
        lane_step(0, 2'b00);
        idle(2);
        check("skip_total", 32'(total), 2);
        do_entry(0); idle(1);
        check("after_err_entry", 32'(total), 3);

        // Fill to capacity.
        for (int i = 0; i < 12; i++) begin
            do_entry(i % 2);
            idle(1);
        end
        check("fill_total", 32'(total), 15);
        check("fill_full", 32'(full), 1);

        // Both lanes enter together at capacity: saturate with overflow.
        step(2'b10, 2'b10);
        step(2'b11, 2'b11);
        step(2'b01, 2'b01);
        exp_q.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0));
        step(2'b00, 2'b00);
        idle(2);
        check("ovf_total", 32'(total), 15);
        check("ovf_full", 32'(full), 1);

        // Lane 0 enters while lane 1 exits at capacity: nets out, no overflow.
        step(2'b01, 2'b10);
        step(2'b11, 2'b11);
        step(2'b10, 2'b01);
        exp_q.push_back(mk(2'b01, 2'b10, 1'b0, 1'b0));
        step(2'b00, 2'b00);
        idle(2);
        check("net_total", 32'(total), 15);

        // Drain to zero, then one more exit underflows.
        for (int i = 0; i < 15; i++) begin
            do_exit(i % 2);
            idle(1);
        end
        check("drain_total", 32'(total), 0);
        check("drain_empty", 32'(empty), 1);
        do_exit(0);
        exp_q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1));
        idle(2);
        check("unf_total", 32'(total), 0);
        check("unf_empty", 32'(empty), 1);

        // Reset mid-sequence with lane 0 in EN2; 11 at release must land in ERR.
        do_entry(0); idle(1);
        check("pre_reset_total", 32'(total), 1);
        lane_step(0, 2'b10);
        lane_step(0, 2'b11);
        reset = 1'b0;
        lane_step(0, 2'b11);
        reset = 1'b1;
        lane_step(0, 2'b11);
        check("midreset_total", 32'(total), 0);
        check("midreset_empty", 32'(empty), 1);
        check("midreset_pulse", 32'({enter_pulse, exit_pulse}), 0);
        lane_step(0, 2'b01);
        lane_step(0, 2'b00);
        idle(2);
        check("post_reset_total", 32'(total), 0);
        do_entry(0); idle(1);
        check("post_reset_entry", 32'(total), 1);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
